// File: rtl/usb_rx_word_assembler.sv
// usb_rx_word_assembler: packs received USB bytes into 32-bit stock_data words
// (first byte in [31:24]). It pulses data_ready for one cycle per completed
// word and pulses frame_error for one cycle whenever a partial word is dropped.
// Optional feature macro: USB_ASM_TIMEOUT_EN. When it is defined, a partial
// word that sits idle for TIMEOUT_CYCLES cycles is dropped.
module usb_rx_word_assembler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        new_packet,
  input  logic        byte_valid,
  input  logic [7:0]  data_in,
  output logic [31:0] stock_data,
  output logic        data_ready,
  output logic        frame_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] shift_p0, shift_nxt;
  logic        complete;
  logic        discard;

  // The idle counter must be able to hold TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 2 || (2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
    $error("usb_rx_word_assembler: need TIMEOUT_CYCLES >= 2 and 2**TIMEOUT_W > TIMEOUT_CYCLES");
  end

`ifdef USB_ASM_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic                 expired;

  assign expired = (state != IDLE) && (idle_cnt == TIMEOUT_LAST);
`endif

  // Next state: new_packet resynchronises first, then byte acceptance, then timeout.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_p0;
    complete  = 1'b0;
    discard   = 1'b0;
    if (new_packet) begin
      // A partial word is lost; a byte in the same cycle starts the new word.
      discard = (state != IDLE);
      if (byte_valid) begin
        state_nxt = B1;
        shift_nxt = {16'h0000, data_in};
      end else begin
        state_nxt = IDLE;
        shift_nxt = '0;
      end
    end else if (byte_valid) begin
      shift_nxt = {shift_p0[15:0], data_in};
      case (state)
        IDLE:    state_nxt = B1;
        B1:      state_nxt = B2;
        B2:      state_nxt = B3;
        default: begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end
      endcase
`ifdef USB_ASM_TIMEOUT_EN
    end else if (expired) begin
      state_nxt = IDLE;
      shift_nxt = '0;
      discard   = 1'b1;
`endif
    end
  end

`ifdef USB_ASM_TIMEOUT_EN
  // Idle counter: restarts on any accepted byte or return to IDLE, counts while a word is partial.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (byte_valid || state_nxt == IDLE) begin
      idle_cnt_nxt = '0;
    end else if (state != IDLE) begin
      idle_cnt_nxt = idle_cnt + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
    end
  end
`endif

  // State, shift register and registered output pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      shift_p0    <= '0;
      stock_data  <= '0;
      data_ready  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_p0    <= shift_nxt;
      data_ready  <= complete;
      frame_error <= discard;
      if (complete) begin
        stock_data <= {shift_p0, data_in};
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_word_assembler.sv
// Bench for usb_rx_word_assembler: a byte-level model predicts the words and
// discards, completed words go into a scoreboard queue, and a monitor pops
// and compares them whenever data_ready fires.
module tb_usb_rx_word_assembler;

  localparam int TO = 8;

  logic        clk;
  logic        n_rst;
  logic        new_packet;
  logic        byte_valid;
  logic [7:0]  data_in;
  logic [31:0] stock_data;
  logic        data_ready;
  logic        frame_error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cnt  = 0;
  logic [31:0] m_shift = '0;
  int          m_idle = 0;
  int          exp_fe = 0;
  int          obs_fe = 0;
  logic [31:0] exp_q[$];

  usb_rx_word_assembler #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .new_packet (new_packet),
    .byte_valid (byte_valid),
    .data_in    (data_in),
    .stock_data (stock_data),
    .data_ready (data_ready),
    .frame_error(frame_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic cycle(input logic np, input logic bv, input logic [7:0] d);
    new_packet = np;
    byte_valid = bv;
    data_in    = d;
    @(posedge clk);
    if (np) begin
      if (m_cnt != 0) exp_fe++;
      if (bv) begin
        m_cnt   = 1;
        m_shift = {24'h0, d};
      end else begin
        m_cnt   = 0;
        m_shift = '0;
      end
      m_idle = 0;
    end else if (bv) begin
      m_shift = {m_shift[23:0], d};
      if (m_cnt == 3) begin
        exp_q.push_back(m_shift);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_idle = 0;
`ifdef USB_ASM_TIMEOUT_EN
    end else if (m_cnt != 0) begin
      if (m_idle == TO - 1) begin
        m_cnt   = 0;
        m_shift = '0;
        m_idle  = 0;
        exp_fe++;
      end else begin
        m_idle++;
      end
`endif
    end
    #1;
    new_packet = 1'b0;
    byte_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  // Continuous scoreboard and pulse invariants, sampled on the falling edge.
  task automatic monitor();
    logic        prev_dr;
    logic        prev_fe;
    logic [31:0] last_word;
    logic [31:0] exp_w;
    prev_dr   = 1'b0;
    prev_fe   = 1'b0;
    last_word = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_dr   = 1'b0;
        prev_fe   = 1'b0;
        last_word = '0;
      end else begin
        checks++;
        if (data_ready === 1'b1 && frame_error === 1'b1) begin
          errors++;
          $display("FAIL pulse_overlap: data_ready=%b frame_error=%b, required not both high", data_ready, frame_error);
        end
        checks++;
        if ((data_ready === 1'b1 && prev_dr) || (frame_error === 1'b1 && prev_fe)) begin
          errors++;
          $display("FAIL pulse_width: data_ready=%b frame_error=%b high two cycles running", data_ready, frame_error);
        end
        checks++;
        if (data_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: stock_data=%h, required no data_ready", stock_data);
          end else begin
            exp_w = exp_q.pop_front();
            if (stock_data !== exp_w) begin
              errors++;
              $display("FAIL word: stock_data=%h, required %h", stock_data, exp_w);
            end
          end
          last_word = stock_data;
        end else if (stock_data !== last_word) begin
          errors++;
          $display("FAIL stock_hold: stock_data=%h changed without data_ready, required %h", stock_data, last_word);
        end
        if (frame_error === 1'b1) obs_fe++;
        prev_dr = (data_ready === 1'b1);
        prev_fe = (frame_error === 1'b1);
      end
    end
  endtask

  task automatic test_reset();
    n_rst      = 1'b1;
    new_packet = 1'b0;
    byte_valid = 1'b0;
    data_in    = 8'h00;
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (stock_data !== 32'h0 || data_ready !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: stock=%h dr=%b fe=%b, required 0 0 0", stock_data, data_ready, frame_error);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (stock_data !== 32'h0 || data_ready !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: stock=%h dr=%b fe=%b, required 0 0 0", stock_data, data_ready, frame_error);
    end
  endtask

  task automatic test_basic_word();
    cycle(1'b1, 1'b1, 8'h12);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++;
      $display("FAIL np_idle_first: frame_error=%b, required 0", frame_error);
    end
    cycle(1'b0, 1'b1, 8'h34);
    cycle(1'b0, 1'b1, 8'h56);
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL early_ready: data_ready=%b, required 0", data_ready);
    end
    cycle(1'b0, 1'b1, 8'h78);
    checks++;
    if (data_ready !== 1'b1 || stock_data !== 32'h12345678 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: dr=%b stock=%h fe=%b, required 1 12345678 0", data_ready, stock_data, frame_error);
    end
    cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (data_ready !== 1'b0 || stock_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_hold: dr=%b stock=%h, required 0 12345678", data_ready, stock_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'hA0 + 8'(i));
      checks++;
      if (data_ready !== ((i == 3) || (i == 7))) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: data_ready=%b, required %b", i, data_ready, (i == 3) || (i == 7));
      end
      want = (i < 3) ? 32'h12345678 : (i < 7) ? 32'hA0A1A2A3 : 32'hA4A5A6A7;
      checks++;
      if (stock_data !== want) begin
        errors++;
        $display("FAIL b2b_stock[%0d]: stock=%h, required %h", i, stock_data, want);
      end
    end
  endtask

  task automatic test_resync();
    cycle(1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b1, 8'h22);
    cycle(1'b1, 1'b1, 8'h33);
    checks++;
    if (frame_error !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL resync_error: fe=%b dr=%b, required 1 0", frame_error, data_ready);
    end
    cycle(1'b0, 1'b1, 8'h44);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++;
      $display("FAIL resync_single: frame_error=%b, required 0", frame_error);
    end
    cycle(1'b0, 1'b1, 8'h55);
    cycle(1'b0, 1'b1, 8'h66);
    checks++;
    if (data_ready !== 1'b1 || stock_data !== 32'h33445566) begin
      errors++;
      $display("FAIL resync_word: dr=%b stock=%h, required 1 33445566", data_ready, stock_data);
    end
    // new_packet with no byte in IDLE: nothing to discard
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++;
      $display("FAIL np_idle: frame_error=%b, required 0", frame_error);
    end
    // new_packet overrides what would have been the 4th byte
    cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b1, 8'h02);
    cycle(1'b0, 1'b1, 8'h03);
    cycle(1'b1, 1'b1, 8'h04);
    checks++;
    if (frame_error !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL override_4th: fe=%b dr=%b, required 1 0", frame_error, data_ready);
    end
    cycle(1'b0, 1'b1, 8'h05);
    cycle(1'b0, 1'b1, 8'h06);
    cycle(1'b0, 1'b1, 8'h07);
    checks++;
    if (data_ready !== 1'b1 || stock_data !== 32'h04050607) begin
      errors++;
      $display("FAIL override_word: dr=%b stock=%h, required 1 04050607", data_ready, stock_data);
    end
  endtask

  task automatic test_reset_mid_word();
    int fe_before;
    cycle(1'b0, 1'b1, 8'h99);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h99);
    cycle(1'b0, 1'b0, 8'h00);
    #2;
    n_rst = 1'b0;
    m_cnt   = 0;
    m_shift = '0;
    m_idle  = 0;
    exp_q.delete();
    #1;
    checks++;
    if (stock_data !== 32'h0 || data_ready !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL midword_reset: stock=%h dr=%b fe=%b, required 0 0 0", stock_data, data_ready, frame_error);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    fe_before = obs_fe;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 8'(i));
      checks++;
      if (frame_error !== 1'b0) begin
        errors++;
        $display("FAIL midword_fe[%0d]: frame_error=%b, required 0", i, frame_error);
      end
    end
    checks++;
    if (data_ready !== 1'b1 || stock_data !== 32'h01020304) begin
      errors++;
      $display("FAIL midword_word: dr=%b stock=%h, required 1 01020304", data_ready, stock_data);
    end
    cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_fe !== fe_before) begin
      errors++;
      $display("FAIL midword_fe_count: frame_error pulses=%0d, required %0d", obs_fe, fe_before);
    end
  endtask

  task automatic test_timeout();
    logic exp_last;
`ifdef USB_ASM_TIMEOUT_EN
    exp_last = 1'b1;
`else
    exp_last = 1'b0;
`endif
    cycle(1'b0, 1'b1, 8'hC1);
    cycle(1'b0, 1'b1, 8'hC2);
    cycle(1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < TO; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      checks++;
      if (frame_error !== ((i == TO - 1) ? exp_last : 1'b0)) begin
        errors++;
        $display("FAIL timeout_fe[%0d]: frame_error=%b, required %b", i, frame_error, (i == TO - 1) ? exp_last : 1'b0);
      end
    end
    cycle(1'b0, 1'b1, 8'hC4);
    checks++;
    if (data_ready !== ~exp_last) begin
      errors++;
      $display("FAIL timeout_4th: data_ready=%b, required %b", data_ready, ~exp_last);
    end
    if (!exp_last) begin
      checks++;
      if (stock_data !== 32'hC1C2C3C4) begin
        errors++;
        $display("FAIL timeout_word: stock=%h, required c1c2c3c4", stock_data);
      end
    end
    cycle(1'b0, 1'b1, 8'hC5);
    cycle(1'b0, 1'b1, 8'hC6);
    cycle(1'b0, 1'b1, 8'hC7);
    checks++;
    if (data_ready !== exp_last) begin
      errors++;
      $display("FAIL timeout_after: data_ready=%b, required %b", data_ready, exp_last);
    end
  endtask

  task automatic test_final();
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_fe !== exp_fe) begin
      errors++;
      $display("FAIL fe_total: frame_error pulses=%0d, required %0d", obs_fe, exp_fe);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL words_missing: %0d expected words never produced, required 0", exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic_word();
    test_back_to_back();
    test_resync();
    test_reset_mid_word();
    test_timeout();
    test_final();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
